// File: rtl/logic_gate_arbiter.sv
// logic_gate_arbiter
//   Round-robin arbiter for two valid/ready requesters that share one bitwise
//   logic-gate datapath. Each cycle at most one requester is granted. The
//   granted operands are evaluated by the selected gate and registered with
//   the winner's ID and op code into a single-entry result register.
//
// Op codes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT (~a), 7 reserved (result 0)
//
// Optional feature macro: LOGIC_GATE_ARB_ERR_EN
//   When defined, the res_err output exists and flags a result produced by op 7.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   reqN_valid / reqN_ready          requester N handshake (N = 0, 1)
//   reqN_a, reqN_b [WIDTH]           requester N operands
//   reqN_op [3]                      requester N op code
//   res_valid / res_ready            result handshake toward the consumer
//   res_data [WIDTH]                 gate result
//   res_id                           requester that produced res_data
//   res_op [3]                       op code that produced res_data
//   res_err                          illegal-op flag (LOGIC_GATE_ARB_ERR_EN only)

module logic_gate_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic [2:0]       res_op
`ifdef LOGIC_GATE_ARB_ERR_EN
  ,
  output logic             res_err
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             last_grant;

  logic             can_load;
  logic             win_vld;
  logic             win_id;
  logic             xfer;

  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic             id_p1;
  logic [2:0]       op_p1;
  logic             err_p1;

  function automatic logic [WIDTH-1:0] eval_gate(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~(a & b);
      3'd3:    r = ~(a | b);
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // ---- stage p0: arbitration and operand select (combinational) ----
  assign can_load = (state_q == EMPTY) || res_ready;

  // On contention the requester that did not win last time is chosen.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      win_vld = 1'b1;
      win_id  = ~last_grant;
    end else if (req0_valid) begin
      win_vld = 1'b1;
      win_id  = 1'b0;
    end else if (req1_valid) begin
      win_vld = 1'b1;
      win_id  = 1'b1;
    end
  end

  // Ready is masked while rst_n is low so that no requester sees a handshake
  // on an edge where the reset discards it.
  assign xfer       = rst_n && can_load && win_vld;
  assign req0_ready = xfer && !win_id;
  assign req1_ready = xfer &&  win_id;

  assign sel_a  = win_id ? req1_a  : req0_a;
  assign sel_b  = win_id ? req1_b  : req0_b;
  assign sel_op = win_id ? req1_op : req0_op;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL: begin
        if (xfer)           state_d = FULL;
        else if (res_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // ---- stage p1: result register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      last_grant <= 1'b1;
      data_p1    <= '0;
      id_p1      <= 1'b0;
      op_p1      <= 3'd0;
      err_p1     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        last_grant <= win_id;
        data_p1    <= eval_gate(sel_op, sel_a, sel_b);
        id_p1      <= win_id;
        op_p1      <= sel_op;
        err_p1     <= (sel_op == 3'd7);
      end
    end
  end

  assign vld_p1    = (state_q == FULL);
  assign res_valid = vld_p1;
  assign res_data  = data_p1;
  assign res_id    = id_p1;
  assign res_op    = op_p1;

`ifdef LOGIC_GATE_ARB_ERR_EN
  assign res_err = err_p1;
`else
  // Illegal-op flag is computed but not exported in this build.
  logic err_unused;
  assign err_unused = err_p1;
`endif

endmodule

// File: tb/tb_logic_gate_arbiter.sv
// Testbench for logic_gate_arbiter: directed scenarios plus randomized traffic.
// A reference model predicts readiness and pushes expected results into a
// queue; an independent monitor compares DUT outputs against the queue.

module tb_logic_gate_arbiter;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] data;
    logic         id;
    logic [2:0]   op;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         res_valid, res_ready, res_id;
  logic [W-1:0] res_data;
  logic [2:0]   res_op;
`ifdef LOGIC_GATE_ARB_ERR_EN
  logic         res_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  exp_t q[$];

  // model state
  logic m_last;
  logic m_valid;

  always #5 clk = ~clk;

  logic_gate_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_op     (res_op)
`ifdef LOGIC_GATE_ARB_ERR_EN
    ,
    .res_err    (res_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-bit truth tables indexed by {a_bit, b_bit}.
  function automatic logic [W-1:0] ref_gate(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [3:0] tt [8];
    logic [W-1:0] r;
    tt = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b0000};
    for (int i = 0; i < W; i++) r[i] = tt[op][{a[i], b[i]}];
    return r;
  endfunction

  // Predictor: evaluates the upcoming edge half a cycle ahead.
  initial begin
    m_last  = 1'b1;
    m_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("ready0_in_reset", {31'd0, req0_ready}, 32'd0);
        check("ready1_in_reset", {31'd0, req1_ready}, 32'd0);
        q.delete();
        m_last  = 1'b1;
        m_valid = 1'b0;
      end else begin
        bit   can_load;
        int   win;
        exp_t e;
        can_load = !m_valid || res_ready;
        if (req0_valid && req1_valid) win = m_last ? 0 : 1;
        else if (req0_valid)          win = 0;
        else if (req1_valid)          win = 1;
        else                          win = -1;
        check("req0_ready", {31'd0, req0_ready}, {31'd0, (can_load && win == 0)});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, (can_load && win == 1)});
        if (can_load && win >= 0) begin
          e.id   = (win == 1);
          e.op   = e.id ? req1_op : req0_op;
          e.data = e.id ? ref_gate(req1_op, req1_a, req1_b) : ref_gate(req0_op, req0_a, req0_b);
          e.err  = (e.op == 3'd7);
          q.push_back(e);
          m_last  = e.id;
          m_valid = 1'b1;
        end else if (can_load) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: inspects the result register just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        check("res_valid", {31'd0, res_valid}, {31'd0, (q.size() != 0)});
        if (res_valid && q.size() != 0) begin
          check("res_data", {24'd0, res_data}, {24'd0, q[0].data});
          check("res_id",   {31'd0, res_id},   {31'd0, q[0].id});
          check("res_op",   {29'd0, res_op},   {29'd0, q[0].op});
`ifdef LOGIC_GATE_ARB_ERR_EN
          check("res_err",  {31'd0, res_err},  {31'd0, q[0].err});
`endif
          if (res_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [2:0] o0, input logic v1, input logic [W-1:0] a1,
                       input logic [W-1:0] b1, input logic [2:0] o1, input logic rr);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    res_ready  = rr;
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_op = 3'd0;
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_op = 3'd1;
    res_ready  = 1'b1;

    // Reset held with both requesters asking
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data",  {24'd0, res_data},  32'd0);
    check("rst_res_id",    {31'd0, res_id},    32'd0);
    check("rst_res_op",    {29'd0, res_op},    32'd0);
`ifdef LOGIC_GATE_ARB_ERR_EN
    check("rst_res_err",   {31'd0, res_err},   32'd0);
`endif
    mon_en = 1'b1;
    rst_n  = 1'b1;

    // Sustained contention: grants alternate starting with requester 0
    for (int i = 0; i < 6; i++)
      drive(1'b1, rnd(), rnd(), 3'($urandom_range(0, 6)),
            1'b1, rnd(), rnd(), 3'($urandom_range(0, 6)), 1'b1);

    // Requester 0 alone walks every gate on F0/3C
    for (int op = 0; op < 7; op++)
      drive(1'b1, 8'hF0, 8'h3C, 3'(op), 1'b0, rnd(), rnd(), 3'd0, 1'b1);

    // Stall while full, then release
    drive(1'b1, 8'h5A, 8'h0F, 3'd4, 1'b1, 8'hC3, 8'h81, 3'd1, 1'b1);
    for (int i = 0; i < 3; i++)
      drive(1'b1, rnd(), rnd(), 3'd2, 1'b1, rnd(), rnd(), 3'd3, 1'b0);
    drive(1'b1, 8'h96, 8'h69, 3'd5, 1'b1, 8'h12, 8'h34, 3'd0, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Requester 1 alone twice, idle gap, then contention
    drive(1'b0, rnd(), rnd(), 3'd0, 1'b1, 8'hA5, 8'h3C, 3'd0, 1'b1);
    drive(1'b0, rnd(), rnd(), 3'd0, 1'b1, 8'hA5, 8'h3C, 3'd4, 1'b1);
    drive(1'b0, rnd(), rnd(), 3'd0, 1'b0, rnd(),  rnd(),  3'd0, 1'b1);
    drive(1'b0, rnd(), rnd(), 3'd0, 1'b0, rnd(),  rnd(),  3'd0, 1'b0);
    drive(1'b1, 8'hFF, 8'h0F, 3'd1, 1'b1, 8'h0F, 8'hF0, 3'd1, 1'b1);
    drive(1'b0, rnd(), rnd(), 3'd0, 1'b0, rnd(),  rnd(),  3'd0, 1'b1);

    // Reserved op from requester 1, then a normal op clears the flag
    drive(1'b0, rnd(), rnd(), 3'd0, 1'b1, 8'hAA, 8'h55, 3'd7, 1'b1);
    drive(1'b0, rnd(), rnd(), 3'd0, 1'b1, 8'hAA, 8'h55, 3'd0, 1'b1);
    drive(1'b0, rnd(), rnd(), 3'd0, 1'b0, rnd(),  rnd(),  3'd0, 1'b1);

    // Randomized traffic with occasional back-pressure and resets
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), rnd(), rnd(), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0), rnd(), rnd(), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0));
      rst_n = ($urandom_range(0, 99) != 0);
    end

    // Drain
    for (int i = 0; i < 4; i++)
      drive(1'b0, rnd(), rnd(), 3'd0, 1'b0, rnd(), rnd(), 3'd0, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("queue_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
